// File: rtl/serv_alu_serdes.sv
// Operand serializer / result deserializer around the bit-serial ALU stage.
// Optional back-to-back handoff in DONE is enabled by SERV_ALU_SERDES_PIPE_EN.
module serv_alu_serdes #(
    parameter int unsigned W = 1,
    parameter int unsigned B = W - 1
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_op_b,
    output logic        o_en,
    output logic        o_cnt0,
    output logic [B:0]  o_rs1,
    output logic [B:0]  o_op_b,
    input  logic [B:0]  i_rd,
    input  logic        i_cmp,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_rd,
    output logic        o_cmp
);

    localparam int unsigned N  = 32 / W;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_load;
    logic            w_last;

    logic [31:0]     r_rs1_sr;
    logic [31:0]     r_op_b_sr;
    logic [31:0]     r_rd_sr;
    logic            r_cmp;
    logic            r_en;
    logic            r_cnt0;
    logic            r_valid;
    logic            r_idle;

    // Next-state and counter; the counter is cleared explicitly at N-1 so it never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_last      = (r_cnt == CW'(N - 1));
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    w_state_nxt = S_IDLE;
                end
`ifdef SERV_ALU_SERDES_PIPE_EN
                if (i_ready && i_valid) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Status flags are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en    <= 1'b0;
            r_cnt0  <= 1'b0;
            r_valid <= 1'b0;
            r_idle  <= 1'b1;
        end else begin
            r_en    <= (w_state_nxt == S_RUN);
            r_cnt0  <= (w_state_nxt == S_RUN) && (w_cnt_nxt == '0);
            r_valid <= (w_state_nxt == S_DONE);
            r_idle  <= (w_state_nxt == S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rs1_sr  <= '0;
            r_op_b_sr <= '0;
            r_rd_sr   <= '0;
            r_cmp     <= 1'b0;
        end else begin
            if (w_load) begin
                r_rs1_sr  <= i_rs1;
                r_op_b_sr <= i_op_b;
            end else if (r_state == S_RUN) begin
                r_rs1_sr  <= r_rs1_sr >> W;
                r_op_b_sr <= r_op_b_sr >> W;
            end
            if (r_state == S_RUN) begin
                r_rd_sr <= {i_rd, r_rd_sr[31:W]};
                if (w_last) begin
                    r_cmp <= i_cmp;
                end
            end
        end
    end

`ifdef SERV_ALU_SERDES_PIPE_EN
    assign o_ready = r_idle | (r_valid & i_ready);
`else
    assign o_ready = r_idle;
`endif
    assign o_en    = r_en;
    assign o_cnt0  = r_cnt0;
    assign o_valid = r_valid;
    assign o_rs1   = r_rs1_sr[B:0];
    assign o_op_b  = r_op_b_sr[B:0];
    assign o_rd    = r_rd_sr;
    assign o_cmp   = r_cmp;

endmodule

// File: tb/tb_serv_alu_serdes.sv
// Bench for serv_alu_serdes: an arithmetic ALU stand-in feeds serial results,
// and transactions, latency, backpressure, reset and back-to-back throughput are checked.
module tb_serv_alu_serdes;

    localparam int W = 1;
    localparam int N = 32 / W;
`ifdef SERV_ALU_SERDES_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif
    localparam int PERIOD = PIPE ? N + 1 : N + 2;

    localparam int OP_ADD  = 0;
    localparam int OP_EQ   = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        c;
    } txn_t;

    logic          clk;
    logic          i_rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [31:0]   i_rs1;
    logic [31:0]   i_op_b;
    logic          o_en;
    logic          o_cnt0;
    logic [W-1:0]  o_rs1;
    logic [W-1:0]  o_op_b;
    logic [W-1:0]  i_rd;
    logic          i_cmp;
    logic          o_valid;
    logic          i_ready;
    logic [31:0]   o_rd;
    logic          o_cmp;

    int n_vec = 0;
    int n_err = 0;
    txn_t stub_q[$];
    txn_t sb_q[$];

    serv_alu_serdes #(.W(W)) dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_rs1   (i_rs1),
        .i_op_b  (i_op_b),
        .o_en    (o_en),
        .o_cnt0  (o_cnt0),
        .o_rs1   (o_rs1),
        .o_op_b  (o_op_b),
        .i_rd    (i_rd),
        .i_cmp   (i_cmp),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_rd    (o_rd),
        .o_cmp   (o_cmp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results from plain word-level arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input int op,
                                  output logic [31:0] r, output logic c);
        case (op)
            OP_ADD:  begin r = a + b; c = 1'($urandom); end
            OP_EQ:   begin r = a - b; c = (a == b); end
            OP_SLT:  begin r = a - b; c = ($signed(a) < $signed(b)); end
            OP_SLTU: begin r = a - b; c = (a < b); end
            default: begin r = a & b; c = 1'($urandom); end
        endcase
    endfunction

    // ALU stand-in: serves the expected result chunk by chunk; only the last compare bit is meaningful.
    txn_t cur;
    int   k = 0;
    bit   have_cur = 1'b0;
    always @(negedge clk) begin
        if (o_en) begin
            if (o_cnt0) begin
                k = 0;
                have_cur = (stub_q.size() != 0);
                if (have_cur) cur = stub_q.pop_front();
                else chk("stub_queue_empty", 32'(stub_q.size()), 32'd1);
            end
            if (have_cur && k < N) begin
                chk("chunk_rs1", 32'(o_rs1), 32'(W'(cur.a >> (k * W))));
                chk("chunk_op_b", 32'(o_op_b), 32'(W'(cur.b >> (k * W))));
                i_rd  = W'(cur.r >> (k * W));
                i_cmp = (k == N - 1) ? cur.c : 1'($urandom);
            end
            k++;
        end else begin
            i_rd  = '0;
            i_cmp = 1'($urandom);
        end
    end

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int op, input int bp);
        logic [31:0] er;
        logic        ec;
        int          waitc;
        model(a, b, op, er, ec);
        i_rs1   = a;
        i_op_b  = b;
        i_valid = 1'b1;
        i_ready = (bp == 0);
        waitc   = 0;
        while (!o_ready && waitc < 100) begin
            @(posedge clk); #1;
            waitc++;
        end
        chk("accept_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        stub_q.push_back('{a, b, er, ec});
        i_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("run_en", 32'(o_en), 32'd1);
            chk("run_cnt0", 32'(o_cnt0), 32'(i == 0));
            chk("run_valid", 32'(o_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("done_valid", 32'(o_valid), 32'd1);
        chk("done_en", 32'(o_en), 32'd0);
        chk("done_ready", 32'(o_ready), PIPE ? 32'(i_ready) : 32'd0);
        chk("done_rd", o_rd, er);
        chk("done_cmp", 32'(o_cmp), 32'(ec));
        for (int i = 1; i < bp; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_ready", 32'(o_ready), 32'd0);
            chk("hold_rd", o_rd, er);
            chk("hold_cmp", 32'(o_cmp), 32'(ec));
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_valid", 32'(o_valid), 32'd0);
        chk("idle_ready", 32'(o_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] er;
        logic        ec;
        txn_t        e;
        int          idx;
        int          nres;
        int          last;
        bit          hs;

        i_rst_n = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_rs1   = '0;
        i_op_b  = '0;
        i_rd    = '0;
        i_cmp   = 1'b0;
        #3 i_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_en", 32'(o_en), 32'd0);
        chk("rst_cnt0", 32'(o_cnt0), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_rd", o_rd, 32'd0);
        chk("rst_cmp", 32'(o_cmp), 32'd0);
        chk("rst_rs1", 32'(o_rs1), 32'd0);
        chk("rst_op_b", 32'(o_op_b), 32'd0);
        @(negedge clk) i_rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed operations.
        run_txn(32'd5, 32'd7, OP_ADD, 0);
        run_txn(32'h8000_0001, 32'h8000_0001, OP_EQ, 0);
        run_txn(32'h8000_0001, 32'h8000_0000, OP_EQ, 0);
        run_txn(32'hFFFF_FFFF, 32'd1, OP_SLT, 0);
        run_txn(32'hFFFF_FFFF, 32'd1, OP_SLTU, 0);
        run_txn(32'h1234_5678, 32'h0FED_CBA9, OP_ADD, 5);

        // Randomized operations with random backpressure.
        for (int t = 0; t < 10; t++) begin
            run_txn($urandom, ((t % 3) == 0) ? 32'h8000_0000 : $urandom,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        // Reset with counter at 10: immediate clear, no result afterwards.
        i_rs1 = $urandom; i_op_b = $urandom; i_valid = 1'b1; i_ready = 1'b1;
        model(i_rs1, i_op_b, OP_ADD, er, ec);
        @(posedge clk); #1;
        stub_q.push_back('{i_rs1, i_op_b, er, ec});
        i_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("pre_rst_en", 32'(o_en), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(o_en), 32'd0);
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_ready", 32'(o_ready), 32'd1);
        chk("mid_rst_rd", o_rd, 32'd0);
        chk("mid_rst_cmp", 32'(o_cmp), 32'd0);
        @(negedge clk) i_rst_n = 1'b1;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", 32'(o_valid), 32'd0);
            chk("post_rst_en", 32'(o_en), 32'd0);
        end
        stub_q.delete();

        // Back-to-back with i_valid and i_ready held high.
        idx = 0; nres = 0; last = -1;
        i_ready = 1'b1;
        i_rs1 = 32'hF0F0_F0F0; i_op_b = 32'hFF00_FF00; i_valid = 1'b1;
        for (int cyc = 0; cyc < 400 && nres < 4; cyc++) begin
            if (o_valid) begin
                if (sb_q.size() == 0) begin
                    chk("b2b_sb_empty", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("b2b_rd", o_rd, e.r);
                    chk("b2b_cmp", 32'(o_cmp), 32'(e.c));
                end
                if (last >= 0) chk("b2b_period", 32'(cyc - last), 32'(PERIOD));
                last = cyc;
                nres++;
            end
            hs = o_ready && i_valid;
            @(posedge clk); #1;
            if (hs) begin
                a = i_rs1; b = i_op_b;
                model(a, b, OP_AND, er, ec);
                stub_q.push_back('{a, b, er, ec});
                sb_q.push_back('{a, b, er, ec});
                idx++;
                i_rs1 = idx[0] ? 32'h0F0F_0F0F : 32'hF0F0_F0F0;
            end
        end
        chk("b2b_count", 32'(nres), 32'd4);
        i_valid = 1'b0;
        repeat (N + 4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
